// File: rtl/csr_counter.sv
// csr_counter: machine counter unit with mcycle, minstret and NUM_HPM
// mhpmcounters (index 3 upward), mcountinhibit, and single-port CSR access
// with a one-cycle registered response.
// Optional feature macro: COUNTER_MCOUNTEREN_EN adds mcounteren (0x306), which
// gates U-mode reads of the 0xCxx mirrors. Without it, 0x306 is illegal.
module csr_counter #(
    parameter int CNT_WIDTH = 64,
    parameter int NUM_HPM   = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   csr_valid_i,
    input  logic                                   csr_we_i,
    input  logic [11:0]                            csr_addr_i,
    input  logic [31:0]                            csr_wdata_i,
    input  logic [1:0]                             mode_i,
    input  logic                                   instr_retire_i,
    input  logic [(NUM_HPM > 0 ? NUM_HPM : 1)-1:0] hpm_event_i,
    output logic                                   csr_ready_o,
    output logic [31:0]                            csr_rdata_o,
    output logic                                   csr_illegal_o
);
    // Slot 1 (time) exists only to keep indices aligned with the CSR layout;
    // it is never written or incremented, so it stays zero.
    localparam int          NCNT      = 3 + NUM_HPM;
    localparam logic [63:0] CNT_BITS  = (64'd1 << NCNT) - 64'd1;
    localparam logic [31:0] IMPL_MASK = CNT_BITS[31:0] & ~32'h2;

    logic [CNT_WIDTH-1:0] cnt_q [NCNT];
    logic [CNT_WIDTH-1:0] cnt_d [NCNT];
    logic [31:0]          inhibit_q;
    logic [31:0]          inhibit_d;
    logic                 ready_q;
    logic                 illegal_q;
    logic                 illegal_d;
    logic [31:0]          rdata_q;
    logic [31:0]          rdata_d;

    logic [4:0]           idx;
    logic                 is_m;
    logic                 idx_ok;
    logic                 hit_cnt_m;
    logic                 hit_cnt_u;
    logic                 hit_inh;
    logic                 hit_en;
    logic                 illegal;
    logic                 wr_ok;
    logic [CNT_WIDTH-1:0] sel_cnt;
    logic [63:0]          sel_ext;
    logic [NCNT-1:0]      ev;
`ifdef COUNTER_MCOUNTEREN_EN
    logic [31:0]          counteren_q;
`endif

    // Address decode and legality check
    always_comb begin
        idx       = csr_addr_i[4:0];
        is_m      = (mode_i == 2'b11);
        idx_ok    = (idx == 5'd0) || (idx == 5'd2) ||
                    ((idx >= 5'd3) && (32'(idx) < 32'(NCNT)));
        hit_cnt_m = (csr_addr_i[11:8] == 4'hB) && (csr_addr_i[6:5] == 2'b00) && idx_ok;
        hit_cnt_u = (csr_addr_i[11:8] == 4'hC) && (csr_addr_i[6:5] == 2'b00) && idx_ok;
        hit_inh   = (csr_addr_i == 12'h320);
`ifdef COUNTER_MCOUNTEREN_EN
        hit_en    = (csr_addr_i == 12'h306);
`else
        hit_en    = 1'b0;
`endif
        illegal = 1'b1;
        if (hit_cnt_m || hit_inh || hit_en) begin
            illegal = !is_m;
        end else if (hit_cnt_u) begin
`ifdef COUNTER_MCOUNTEREN_EN
            illegal = csr_we_i || (!is_m && !counteren_q[idx]);
`else
            illegal = csr_we_i;
`endif
        end
    end

    // Read-data mux; illegal or idle cycles return zero
    always_comb begin
        sel_cnt = '0;
        for (int k = 0; k < NCNT; k++) begin
            if (idx == 5'(k)) sel_cnt = cnt_q[k];
        end
        sel_ext = 64'(sel_cnt);
        if (hit_inh) begin
            rdata_d = inhibit_q;
`ifdef COUNTER_MCOUNTEREN_EN
        end else if (hit_en) begin
            rdata_d = counteren_q;
`endif
        end else begin
            rdata_d = csr_addr_i[7] ? sel_ext[63:32] : sel_ext[31:0];
        end
        if (illegal || !csr_valid_i) rdata_d = '0;
        illegal_d = csr_valid_i && illegal;
        wr_ok     = csr_valid_i && csr_we_i && !illegal;
    end

    // Counter next-state: a CSR write to a counter replaces its increment
    always_comb begin
        ev    = '0;
        ev[0] = 1'b1;
        ev[2] = instr_retire_i;
        for (int i = 0; i < NUM_HPM; i++) ev[3+i] = hpm_event_i[i];
        for (int k = 0; k < NCNT; k++) begin
            cnt_d[k] = cnt_q[k];
            if (wr_ok && hit_cnt_m && (idx == 5'(k))) begin
                if (csr_addr_i[7]) cnt_d[k] = {csr_wdata_i[CNT_WIDTH-33:0], cnt_q[k][31:0]};
                else               cnt_d[k] = {cnt_q[k][CNT_WIDTH-1:32], csr_wdata_i};
            end else if (ev[k] && !inhibit_q[k]) begin
                cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
            end
        end
        inhibit_d = (wr_ok && hit_inh) ? (csr_wdata_i & IMPL_MASK) : inhibit_q;
    end

    // State and response registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NCNT; k++) cnt_q[k] <= '0;
            inhibit_q <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            for (int k = 0; k < NCNT; k++) cnt_q[k] <= cnt_d[k];
            inhibit_q <= inhibit_d;
            ready_q   <= csr_valid_i;
            rdata_q   <= rdata_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef COUNTER_MCOUNTEREN_EN
    // mcounteren register, M-mode write only
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                 counteren_q <= '0;
        else if (wr_ok && hit_en)    counteren_q <= csr_wdata_i & IMPL_MASK;
    end
`endif

    assign csr_ready_o   = ready_q;
    assign csr_rdata_o   = rdata_q;
    assign csr_illegal_o = illegal_q;

endmodule
